// File: rtl/mc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mc_pkg                                                                      |
// | Shared state, opcode, aluop and pcsrc encodings for the multicycle decoder. |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package mc_pkg;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_MEMADR  = 4'd2,
        ST_MEMRD   = 4'd3,
        ST_MEMWB   = 4'd4,
        ST_MEMWR   = 4'd5,
        ST_EXECUTE = 4'd6,
        ST_ALUWB   = 4'd7,
        ST_BRANCH  = 4'd8,
        ST_ADDIEX  = 4'd9,
        ST_ADDIWB  = 4'd10,
        ST_JUMP    = 4'd11
    } mc_state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage
`default_nettype wire

// File: rtl/mc_wait_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mc_wait_timer                                                               |
// | Counts consecutive memory-wait cycles; expired flags the last allowed one.  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module mc_wait_timer #(
    parameter int TIMEOUT = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic waiting,
    input  logic clear,
    output logic expired
);

    generate
        if (TIMEOUT == 0) begin : g_disabled
            logic w_unused;
            assign w_unused = &{1'b0, clk, reset_n, waiting, clear};
            assign expired  = 1'b0;
        end else begin : g_enabled
            localparam int CW = $clog2(TIMEOUT + 1);
            localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);

            logic [CW-1:0] r_count;

            // Saturates at the last allowed value so it can never wrap.
            always_ff @(posedge clk) begin
                if (!reset_n || clear || !waiting) begin
                    r_count <= '0;
                end else if (r_count != C_LAST) begin
                    r_count <= r_count + CW'(1);
                end
            end

            assign expired = waiting && (r_count == C_LAST);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/mc_maindec.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mc_maindec                                                                  |
// | Multicycle MIPS main control FSM with memory-ready stall and wait timeout.  |
// | Optional bne support when MC_BNE_EN is defined.                             |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module mc_maindec #(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 2,
    parameter int TIMEOUT = 0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [OP_W-1:0]    op,
    input  logic               mem_ready,
    output logic               iord,
    output logic               irwrite,
    output logic               pcwrite,
    output logic               branch,
    output logic               regwrite,
    output logic               memwrite,
    output logic               memtoreg,
    output logic               regdst,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         pcsrc,
    output logic [ALUOP_W-1:0] aluop,
    output logic               illegal_op,
    output logic               mem_err,
    output logic               branch_ne
);

    import mc_pkg::*;

    mc_state_t  r_state;
    mc_state_t  w_next;
    mc_state_t  w_dstate;
    logic [5:0] w_opc;
    logic       r_mem_err;
    logic       r_bne;
    logic       w_illegal;
    logic       w_waiting;
    logic       w_clear;
    logic       w_expired;

    logic       w_iord, w_irwrite, w_pcwrite, w_branch, w_regwrite, w_memwrite;
    logic       w_memtoreg, w_regdst, w_alusrca, w_illegal_out, w_branch_ne;
    logic [1:0] w_alusrcb, w_pcsrc, w_aluop;

    assign w_opc     = 6'(op);
    assign w_waiting = ((r_state == ST_FETCH) || (r_state == ST_MEMRD) ||
                        (r_state == ST_MEMWR)) && !mem_ready;

    always_comb begin
        w_next    = r_state;
        w_illegal = 1'b0;
        case (r_state)
            ST_FETCH:   if (mem_ready) w_next = ST_DECODE;
            ST_DECODE: begin
                case (w_opc)
                    OP_LW, OP_SW: w_next = ST_MEMADR;
                    OP_RTYPE:     w_next = ST_EXECUTE;
                    OP_BEQ:       w_next = ST_BRANCH;
`ifdef MC_BNE_EN
                    OP_BNE:       w_next = ST_BRANCH;
`endif
                    OP_ADDI:      w_next = ST_ADDIEX;
                    OP_J:         w_next = ST_JUMP;
                    default: begin
                        w_next    = ST_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            ST_MEMADR:  w_next = (w_opc == OP_LW) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:   if (mem_ready) w_next = ST_MEMWB;
            ST_MEMWR:   if (mem_ready) w_next = ST_FETCH;
            ST_EXECUTE: w_next = ST_ALUWB;
            ST_ADDIEX:  w_next = ST_ADDIWB;
            default:    w_next = ST_FETCH;
        endcase
        // A timed-out wait abandons the access; mem_ready already wins via w_waiting.
        if (w_expired) w_next = ST_FETCH;
    end

    assign w_clear = w_expired || (w_next != r_state);

    mc_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .waiting (w_waiting),
        .clear   (w_clear),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= ST_FETCH;
            r_mem_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_expired) r_mem_err <= 1'b1;
        end
    end

`ifdef MC_BNE_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_bne <= 1'b0;
        end else if (r_state == ST_DECODE) begin
            r_bne <= (w_opc == OP_BNE);
        end
    end
`else
    assign r_bne = 1'b0;
`endif

    // Reset forces FETCH-style selects; enables are additionally masked below.
    assign w_dstate = reset_n ? r_state : ST_FETCH;

    always_comb begin
        w_iord        = 1'b0;
        w_irwrite     = 1'b0;
        w_pcwrite     = 1'b0;
        w_branch      = 1'b0;
        w_regwrite    = 1'b0;
        w_memwrite    = 1'b0;
        w_memtoreg    = 1'b0;
        w_regdst      = 1'b0;
        w_alusrca     = 1'b0;
        w_alusrcb     = 2'b00;
        w_pcsrc       = PCSRC_ALU;
        w_aluop       = ALUOP_ADD;
        w_illegal_out = 1'b0;
        w_branch_ne   = 1'b0;
        case (w_dstate)
            ST_FETCH: begin
                w_alusrcb = 2'b01;
                w_irwrite = mem_ready;
                w_pcwrite = mem_ready;
            end
            ST_DECODE: begin
                w_alusrcb     = 2'b11;
                w_illegal_out = w_illegal;
            end
            ST_MEMADR: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
            end
            ST_MEMRD:  w_iord = 1'b1;
            ST_MEMWB: begin
                w_regwrite = 1'b1;
                w_memtoreg = 1'b1;
            end
            ST_MEMWR: begin
                w_iord     = 1'b1;
                w_memwrite = !w_expired;
            end
            ST_EXECUTE: begin
                w_alusrca = 1'b1;
                w_aluop   = ALUOP_FUNCT;
            end
            ST_ALUWB: begin
                w_regdst   = 1'b1;
                w_regwrite = 1'b1;
            end
            ST_BRANCH: begin
                w_alusrca   = 1'b1;
                w_aluop     = ALUOP_SUB;
                w_pcsrc     = PCSRC_ALUOUT;
                w_branch    = !r_bne;
                w_branch_ne = r_bne;
            end
            ST_ADDIEX: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
            end
            ST_ADDIWB: w_regwrite = 1'b1;
            ST_JUMP: begin
                w_pcwrite = 1'b1;
                w_pcsrc   = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

    assign iord       = w_iord;
    assign irwrite    = w_irwrite  && reset_n;
    assign pcwrite    = w_pcwrite  && reset_n;
    assign branch     = w_branch   && reset_n;
    assign regwrite   = w_regwrite && reset_n;
    assign memwrite   = w_memwrite && reset_n;
    assign memtoreg   = w_memtoreg;
    assign regdst     = w_regdst;
    assign alusrca    = w_alusrca;
    assign alusrcb    = w_alusrcb;
    assign pcsrc      = w_pcsrc;
    assign aluop      = ALUOP_W'(w_aluop);
    assign illegal_op = w_illegal_out;
    assign mem_err    = r_mem_err;
    assign branch_ne  = w_branch_ne && reset_n;

endmodule
`default_nettype wire

// File: tb/tb_mc_maindec.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mc_maindec                                                               |
// | Directed per-cycle vectors with a queued scoreboard; TIMEOUT=4 instance.    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_mc_maindec;

    localparam logic [5:0] C_RT = 6'b000000, C_LW = 6'b100011, C_SW = 6'b101011;
    localparam logic [5:0] C_BEQ = 6'b000100, C_BNE = 6'b000101, C_ADDI = 6'b001000;
    localparam logic [5:0] C_J = 6'b000010, C_BAD = 6'b111111;

    localparam int T_RESET = 0, T_FETCH = 1, T_DEC = 2, T_DECILL = 3, T_MEMADR = 4;
    localparam int T_MEMRD = 5, T_MEMWB = 6, T_MEMWR = 7, T_EXE = 8, T_ALUWB = 9;
    localparam int T_BR = 10, T_BRNE = 11, T_ADDIEX = 12, T_ADDIWB = 13, T_JUMP = 14;

    // Observed vector bit positions.
    localparam int B_IORD = 17, B_IRW = 16, B_PCW = 15, B_BR = 14, B_RW = 13, B_MW = 12;
    localparam int B_M2R = 11, B_RDST = 10, B_SRCA = 9, B_SRCB = 7, B_PCSRC = 5;
    localparam int B_ALUOP = 3, B_ILL = 2, B_ERR = 1, B_BNE = 0;

    typedef struct {
        logic [17:0] e;
        logic [17:0] m;
        string       name;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] op;
    logic       mem_ready;
    logic       iord, irwrite, pcwrite, branch, regwrite, memwrite;
    logic       memtoreg, regdst, alusrca, illegal_op, mem_err, branch_ne;
    logic [1:0] alusrcb, pcsrc, aluop;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   step  = 0;

    mc_maindec #(
        .OP_W    (6),
        .ALUOP_W (2),
        .TIMEOUT (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op         (op),
        .mem_ready  (mem_ready),
        .iord       (iord),
        .irwrite    (irwrite),
        .pcwrite    (pcwrite),
        .branch     (branch),
        .regwrite   (regwrite),
        .memwrite   (memwrite),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .aluop      (aluop),
        .illegal_op (illegal_op),
        .mem_err    (mem_err),
        .branch_ne  (branch_ne)
    );

    always #5 clk = ~clk;

    // Hand-derived per-state outputs; unlisted selects are don't-care, enables must be 0.
    function automatic exp_t expv(input int st, input logic rdy, input logic err,
                                  input logic errcare);
        exp_t x;
        x.e = '0;
        x.m = '0;
        x.m[B_IRW] = 1; x.m[B_PCW] = 1; x.m[B_BR] = 1; x.m[B_RW] = 1; x.m[B_MW] = 1;
        x.m[B_ILL] = 1; x.m[B_BNE] = 1;
        x.m[B_ERR] = errcare; x.e[B_ERR] = err;
        x.name = "";
        case (st)
            T_RESET, T_FETCH: begin
                x.name = (st == T_RESET) ? "reset" : "fetch";
                x.m[B_IORD] = 1; x.m[B_SRCA] = 1;
                x.m[B_SRCB+:2] = '1; x.m[B_ALUOP+:2] = '1; x.m[B_PCSRC+:2] = '1;
                x.e[B_SRCB+:2] = 2'b01;
                if (st == T_FETCH) begin x.e[B_IRW] = rdy; x.e[B_PCW] = rdy; end
            end
            T_DEC, T_DECILL: begin
                x.name = (st == T_DEC) ? "decode" : "decode_illegal";
                x.m[B_SRCB+:2] = '1; x.m[B_ALUOP+:2] = '1;
                x.e[B_SRCB+:2] = 2'b11;
                x.e[B_ILL] = (st == T_DECILL);
            end
            T_MEMADR: begin
                x.name = "memadr"; x.m[B_SRCA] = 1; x.m[B_SRCB+:2] = '1;
                x.e[B_SRCA] = 1; x.e[B_SRCB+:2] = 2'b10;
            end
            T_MEMRD: begin x.name = "memrd"; x.m[B_IORD] = 1; x.e[B_IORD] = 1; end
            T_MEMWB: begin
                x.name = "memwb"; x.m[B_M2R] = 1; x.m[B_RDST] = 1;
                x.e[B_RW] = 1; x.e[B_M2R] = 1;
            end
            T_MEMWR: begin
                x.name = "memwr"; x.m[B_IORD] = 1; x.e[B_IORD] = 1; x.e[B_MW] = 1;
            end
            T_EXE: begin
                x.name = "execute"; x.m[B_SRCA] = 1; x.m[B_SRCB+:2] = '1; x.m[B_ALUOP+:2] = '1;
                x.e[B_SRCA] = 1; x.e[B_ALUOP+:2] = 2'b10;
            end
            T_ALUWB: begin
                x.name = "aluwb"; x.m[B_RDST] = 1; x.e[B_RDST] = 1; x.e[B_RW] = 1;
            end
            T_BR, T_BRNE: begin
                x.name = (st == T_BR) ? "branch" : "branch_ne";
                x.m[B_SRCA] = 1; x.m[B_SRCB+:2] = '1; x.m[B_ALUOP+:2] = '1; x.m[B_PCSRC+:2] = '1;
                x.e[B_SRCA] = 1; x.e[B_ALUOP+:2] = 2'b01; x.e[B_PCSRC+:2] = 2'b01;
                x.e[B_BR]  = (st == T_BR);
                x.e[B_BNE] = (st == T_BRNE);
            end
            T_ADDIEX: begin
                x.name = "addiex"; x.m[B_SRCA] = 1; x.m[B_SRCB+:2] = '1; x.m[B_ALUOP+:2] = '1;
                x.e[B_SRCA] = 1; x.e[B_SRCB+:2] = 2'b10;
            end
            T_ADDIWB: begin
                x.name = "addiwb"; x.m[B_RDST] = 1; x.e[B_RW] = 1;
            end
            T_JUMP: begin
                x.name = "jump"; x.m[B_PCSRC+:2] = '1;
                x.e[B_PCW] = 1; x.e[B_PCSRC+:2] = 2'b10;
            end
            default: x.name = "unknown";
        endcase
        return x;
    endfunction

    task automatic cyc(input int st, input logic rn, input logic [5:0] o, input logic rdy,
                       input logic err = 1'b0, input logic errcare = 1'b1);
        reset_n   = rn;
        op        = o;
        mem_ready = rdy;
        q.push_back(expv(st, rdy, err, errcare));
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t x;
            logic [17:0] obs;
            x   = q.pop_front();
            obs = {iord, irwrite, pcwrite, branch, regwrite, memwrite, memtoreg, regdst,
                   alusrca, alusrcb, pcsrc, aluop, illegal_op, mem_err, branch_ne};
            n_vec++;
            step++;
            if (((obs ^ x.e) & x.m) != 18'd0) begin
                n_err++;
                $display("FAIL step %0d %s: got %b want %b care %b", step, x.name, obs, x.e, x.m);
            end
        end
    end

    initial begin
        reset_n = 1'b0; op = C_LW; mem_ready = 1'b1;
        @(posedge clk); #1;
        cyc(T_RESET, 0, C_LW, 1);

        // lw, no stalls: 5 cycles
        cyc(T_FETCH, 1, C_LW, 1); cyc(T_DEC, 1, C_LW, 1); cyc(T_MEMADR, 1, C_LW, 1);
        cyc(T_MEMRD, 1, C_LW, 1); cyc(T_MEMWB, 1, C_LW, 1);
        // sw with 3 wait cycles in MEMWR
        cyc(T_FETCH, 1, C_SW, 1); cyc(T_DEC, 1, C_SW, 1); cyc(T_MEMADR, 1, C_SW, 1);
        for (int i = 0; i < 3; i++) cyc(T_MEMWR, 1, C_SW, 0);
        cyc(T_MEMWR, 1, C_SW, 1);
        // R-type, beq, addi, j back-to-back
        cyc(T_FETCH, 1, C_RT, 1); cyc(T_DEC, 1, C_RT, 1); cyc(T_EXE, 1, C_RT, 1);
        cyc(T_ALUWB, 1, C_RT, 1);
        cyc(T_FETCH, 1, C_BEQ, 1); cyc(T_DEC, 1, C_BEQ, 1); cyc(T_BR, 1, C_BEQ, 1);
        cyc(T_FETCH, 1, C_ADDI, 1); cyc(T_DEC, 1, C_ADDI, 1); cyc(T_ADDIEX, 1, C_ADDI, 1);
        cyc(T_ADDIWB, 1, C_ADDI, 1);
        cyc(T_FETCH, 1, C_J, 1); cyc(T_DEC, 1, C_J, 1); cyc(T_JUMP, 1, C_J, 1);
        // illegal opcode
        cyc(T_FETCH, 1, C_BAD, 1); cyc(T_DECILL, 1, C_BAD, 1);
        // bne
        cyc(T_FETCH, 1, C_BNE, 1);
`ifdef MC_BNE_EN
        cyc(T_DEC, 1, C_BNE, 1); cyc(T_BRNE, 1, C_BNE, 1);
`else
        cyc(T_DECILL, 1, C_BNE, 1);
`endif
        // fetch stall, then mem_ready low in DECODE is ignored
        cyc(T_FETCH, 1, C_J, 0); cyc(T_FETCH, 1, C_J, 1); cyc(T_DEC, 1, C_J, 0);
        cyc(T_JUMP, 1, C_J, 0);
        // lw stuck in MEMRD: timeout after 4 cycles, sticky mem_err
        cyc(T_FETCH, 1, C_LW, 1); cyc(T_DEC, 1, C_LW, 1); cyc(T_MEMADR, 1, C_LW, 1);
        for (int i = 0; i < 4; i++) cyc(T_MEMRD, 1, C_LW, 0);
        cyc(T_FETCH, 1, C_J, 1, 1); cyc(T_DEC, 1, C_J, 1, 1); cyc(T_JUMP, 1, C_J, 1, 1);
        cyc(T_RESET, 0, C_J, 1, 0, 0);
        // reset mid-wait in MEMWR
        cyc(T_FETCH, 1, C_SW, 1); cyc(T_DEC, 1, C_SW, 1); cyc(T_MEMADR, 1, C_SW, 1);
        cyc(T_MEMWR, 1, C_SW, 0);
        cyc(T_RESET, 0, C_SW, 0);
        // timeout while stalled in FETCH: stays in FETCH, error set
        for (int i = 0; i < 4; i++) cyc(T_FETCH, 1, C_RT, 0);
        cyc(T_FETCH, 1, C_RT, 1, 1); cyc(T_DEC, 1, C_RT, 1, 1); cyc(T_EXE, 1, C_RT, 1, 1);
        cyc(T_ALUWB, 1, C_RT, 1, 1);

        repeat (2) @(negedge clk);
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
